// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx : parallel-in serial-out transmitter
//
// Takes a WIDTH-bit word over a valid/ready handshake and sends it MSB first,
// one bit per clk. A sipo sampling serial_out on the same clock holds the
// original word after WIDTH edges.
//
// Configuration macro: PISO_PARITY_EN
//   undefined (default) : frame = WIDTH data bits
//   defined             : frame = WIDTH data bits + 1 even-parity bit (^word)
//
// Ports
//   clk           in   1      rising-edge clock
//   reset         in   1      synchronous, active-low reset
//   load_valid    in   1      producer has a word on parallel_in
//   load_ready    out  1      a word is accepted this cycle if load_valid
//   parallel_in   in   WIDTH  word to transmit
//   serial_out    out  1      serial data, MSB first
//   serial_valid  out  1      serial_out carries a frame bit this cycle
//   frame_start   out  1      high with the first (MSB) bit of a frame
//   frame_last    out  1      high with the final bit of a frame
//   debug_state   out  2      current FSM state (0=IDLE, 1=SHIFT, 2=PARITY)
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high. load_ready depends only on internal state and
// reset, never on load_valid. The producer holds parallel_in stable while
// load_valid is high and load_ready is low; the word is captured on the
// accepting edge, so later changes to parallel_in do not affect the frame.
// -----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic [1:0]       debug_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             last_data;
    logic             frame_end;

`ifdef PISO_PARITY_EN
    logic parity_bit;
`endif

    // Next-state and handshake logic
    always_comb begin
        state_next = state;
        last_data  = (state == SHIFT) && (bit_cnt == LAST_CNT);
`ifdef PISO_PARITY_EN
        frame_end  = (state == PARITY);
`else
        frame_end  = last_data;
`endif
        // Ready in IDLE, and in the final frame cycle so frames chain without a gap.
        load_ready = reset && ((state == IDLE) || frame_end);
        accept     = load_valid && load_ready;

        case (state)
            IDLE: begin
                if (accept) state_next = SHIFT;
            end
            SHIFT: begin
                if (last_data) begin
`ifdef PISO_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = accept ? SHIFT : IDLE;
`endif
                end
            end
            PARITY: begin
                state_next = accept ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef PISO_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                shift_reg <= parallel_in;
                bit_cnt   <= '0;
`ifdef PISO_PARITY_EN
                parity_bit <= ^parallel_in;
`endif
            end else if ((state == SHIFT) && !last_data) begin
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                bit_cnt   <= bit_cnt + CNT_W'(1);
            end else if (state_next == IDLE) begin
                // Frame done with nothing queued: park the datapath at zero.
                shift_reg <= '0;
                bit_cnt   <= '0;
            end
        end
    end

    // Outputs are decoded from registers only; no input-to-output path
    // except load_ready's dependence on reset.
    always_comb begin
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        frame_last   = 1'b0;
        case (state)
            SHIFT: begin
                serial_out   = shift_reg[WIDTH-1];
                serial_valid = 1'b1;
                frame_start  = (bit_cnt == '0);
`ifndef PISO_PARITY_EN
                frame_last   = last_data;
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                serial_out   = parity_bit;
                serial_valid = 1'b1;
                frame_last   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign debug_state = state;

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx : directed self-checking bench for piso_tx (WIDTH=4)
//
// Each accepted word pushes its expected frame bits {data, start, last} onto
// exp_q; every cycle the monitor pops one entry and compares the serial
// outputs, or expects an idle line when the queue is empty. The bench's own
// view of readiness is "queue empty and reset high".
// -----------------------------------------------------------------------------
module tb_piso_tx;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] parallel_in;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             frame_last;
    logic [1:0]       debug_state;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {serial_out, frame_start, frame_last}
    logic [2:0] exp_q[$];

    // Bench-side sipo receiving the serial stream
    logic [WIDTH-1:0] sipo_word;

    piso_tx #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .parallel_in  (parallel_in),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .frame_last   (frame_last),
        .debug_state  (debug_state)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (!reset) sipo_word <= '0;
        else if (serial_valid) sipo_word <= {sipo_word[WIDTH-2:0], serial_out};
    end

    // ---------------- check helpers ----------------
    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_word(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic push_frame(input logic [WIDTH-1:0] d);
        for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef PISO_PARITY_EN
            exp_q.push_back({d[i], (i == WIDTH - 1), 1'b0});
`else
            exp_q.push_back({d[i], (i == WIDTH - 1), (i == 0)});
`endif
        end
`ifdef PISO_PARITY_EN
        exp_q.push_back({^d, 1'b0, 1'b1});
`endif
    endtask

    task automatic monitor();
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_bit("serial_valid", serial_valid, 1'b1);
            check_bit("serial_out",   serial_out,   e[2]);
            check_bit("frame_start",  frame_start,  e[1]);
            check_bit("frame_last",   frame_last,   e[0]);
        end else begin
            check_bit("idle_valid", serial_valid, 1'b0);
            check_bit("idle_out",   serial_out,   1'b0);
            check_bit("idle_start", frame_start,  1'b0);
            check_bit("idle_last",  frame_last,   1'b0);
        end
        check_bit("load_ready", load_ready, reset && (exp_q.size() == 0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d);
        load_valid  = v;
        parallel_in = d;
        if (v && reset && (exp_q.size() == 0)) push_frame(d);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0);
            step();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset       = 1'b0;
        load_valid  = 1'b1;   // must be ignored during reset
        parallel_in = 4'hF;
        step();
        step();
        check_word("reset_state", 8'(debug_state), 8'd0);

        // Test 1: single frame 4'b1011, then sipo holds the word
        reset = 1'b1;
        drive(1'b0, '0);
        step();
        drive(1'b1, 4'b1011);
        step();
        for (int i = 0; i < WIDTH; i++) begin
            drive(1'b0, '0);
            step();
        end
`ifndef PISO_PARITY_EN
        check_word("sipo_word", 8'(sipo_word), 8'hB);
`endif
        idle_cycles(2);

        // Test 2: back-to-back 4'hA then 4'h5 with load_valid held
        drive(1'b1, 4'hA);
        step();
        for (int i = 0; i < WIDTH - 1; i++) begin
            drive(1'b1, 4'h5);
            step();
        end
        drive(1'b1, 4'h5);   // accepted in the final cycle of 4'hA
        step();
        for (int i = 0; i < WIDTH; i++) begin
            drive(1'b0, '0);
            step();
        end
        idle_cycles(1);

        // Test 3: load attempts while busy are ignored
        drive(1'b1, 4'h0);
        step();
        drive(1'b0, '0);
        step();
        drive(1'b1, 4'hF);
        step();
        drive(1'b1, 4'hF);
        step();
        drive(1'b0, '0);
        step();
        idle_cycles(2);

        // Test 4: reset in cycle 2 of 4'hC aborts the frame
        drive(1'b1, 4'hC);
        step();
        drive(1'b0, '0);
        step();
        reset = 1'b0;
        exp_q.delete();
        drive(1'b0, '0);
        step();
        check_word("abort_state", 8'(debug_state), 8'd0);
        reset = 1'b1;
        idle_cycles(1);
        drive(1'b1, 4'h3);
        step();
        idle_cycles(WIDTH + 2);

        // Test 5: parallel_in changes after accept do not affect the frame
        drive(1'b1, 4'h9);
        step();
        drive(1'b0, 4'h6);
        step();
        idle_cycles(WIDTH + 1);

`ifdef PISO_PARITY_EN
        // Test 6: parity bit follows the data bits
        drive(1'b1, 4'b1011);
        step();
        idle_cycles(WIDTH + 1);
        drive(1'b1, 4'b1001);
        step();
        idle_cycles(WIDTH + 1);
`endif

        // Randomised single and chained frames
        for (int n = 0; n < 20; n++) begin
            logic [WIDTH-1:0] w;
            w = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            drive(1'b1, w);
            step();
            for (int c = 0; c < 8; c++) begin
                if (exp_q.size() == 0 && $urandom_range(0, 1) == 1) break;
                w = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
                drive(1'(($urandom_range(0, 3) == 0)), w);
                step();
            end
        end
        idle_cycles(WIDTH + 3);

        check_word("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
